// File: rtl/lfsr_stream_if.sv
// Output stream bundle for lfsr_stream: word, valid/ready handshake and lockup pulse.
interface lfsr_stream_if #(
  parameter int WIDTH = 32
) ();
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             ready_i;
  logic             lockup_o;

  modport master (
    output valid_o,
    output data_o,
    output lockup_o,
    input  ready_i
  );

  modport slave (
    input  valid_o,
    input  data_o,
    input  lockup_o,
    output ready_i
  );
endinterface

// File: rtl/lfsr_stream.sv
// Parametrised Fibonacci LFSR word source with warm-up phase and valid/ready output.
// Define LFSR_LOCKUP_RECOVER_EN to replace an all-zero advance with SEED and pulse lockup_o.
module lfsr_stream #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] TAPS   = 32'h088C_8892,
  parameter logic [WIDTH-1:0] SEED   = 32'h00BD_6D01,
  parameter int               STEPS  = 1,
  parameter int               WARMUP = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  lfsr_stream_if.master    io_stream
);

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] WARM_CNT   = 8'(WARMUP);
  localparam state_t     ENTRY_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_data;
  logic [7:0]       r_wcnt;
  logic             r_lockup;
  logic             w_valid;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_advResult;
  logic             w_advance;
  logic             w_lockup;
  logic [7:0]       w_wcntInc;
  logic [WIDTH-1:0] w_loadValue;

  // STEPS single shifts unrolled into one combinational advance
  always_comb begin
    w_shifted = r_data;
    for (int k = 0; k < STEPS; k++) begin
      w_shifted = {w_shifted[WIDTH-2:0], ^(w_shifted & TAPS)};
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign w_advResult = (w_shifted == '0) ? SEED : w_shifted;
  assign w_lockup    = w_advance && (w_shifted == '0);
`else
  assign w_advResult = w_shifted;
  assign w_lockup    = 1'b0;
`endif

  assign w_advance   = en_i && ((r_state == ST_WARM) || (w_valid && io_stream.ready_i));
  assign w_wcntInc   = r_wcnt + 8'd1;
  assign w_loadValue = (seed_i == '0) ? SEED : seed_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ENTRY_STATE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (load_i) begin
      w_nextState = ENTRY_STATE;
    end else if ((r_state == ST_WARM) && en_i && (w_wcntInc == WARM_CNT)) begin
      w_nextState = ST_RUN;
    end
  end

  always_comb begin
    w_valid = (r_state == ST_RUN);
  end

  // Load wins over any same-cycle handshake, so the loaded word is never advanced
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data   <= SEED;
      r_wcnt   <= 8'd0;
      r_lockup <= 1'b0;
    end else if (load_i) begin
      r_data   <= w_loadValue;
      r_wcnt   <= 8'd0;
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= w_lockup;
      if (w_advance) begin
        r_data <= w_advResult;
      end
      if ((r_state == ST_WARM) && en_i) begin
        r_wcnt <= w_wcntInc;
      end
    end
  end

  assign io_stream.valid_o  = w_valid;
  assign io_stream.data_o   = r_data;
  assign io_stream.lockup_o = r_lockup;

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised Fibonacci LFSR pseudo-random word source with a valid/ready output stream. This is the next-generation replacement for the fixed 32-bit LFSR. It adds configurable width, taps, seed and bits-per-step, runtime seed loading, a post-reset warm-up phase, and all-zero lockup recovery. It feeds test-pattern generators, scramblers and randomised arbitration in the same clock domain.

## Interface
- WIDTH, 32, state and output word width in bits; legal range 4..64.
- TAPS, 32'h088C_8892, feedback mask; bit i set means state bit i is XORed into the feedback.
- SEED, 32'h00BD_6D01, reset and recovery state; must be non-zero.
- STEPS, 1, single-bit shifts per advance; legal range 1..WIDTH.
- WARMUP, 0, advances performed after reset or load before valid_o asserts; legal range 0..255.
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  reset; synchronous and active-high.
- en_i  in  1  global advance enable; when low, all state is frozen (load_i still acts).
- load_i  in  1  one-cycle seed load strobe.
- seed_i  in  WIDTH  seed value, sampled when load_i=1.
- ready_i  in  1  consumer accepts data_o this cycle.
- valid_o  out  1  data_o holds a fresh word.
- data_o  out  WIDTH  current LFSR state.
- lockup_o  out  1  one-cycle pulse on all-zero recovery.

## Operation
- Single shift: s' = (s << 1) | fb, with fb = XOR over i of (s[i] & TAPS[i]). The MSB is dropped. The new bit enters at bit 0.
- One advance applies STEPS single shifts combinationally, unrolled, within one cycle.
- The FSM has two states, WARM and RUN, plus an 8-bit warm counter wcnt.
- WARM:
  - valid_o=0.
  - Each cycle with en_i=1: advance, wcnt++.
  - When wcnt reaches WARMUP, go to RUN.
  - If WARMUP=0, WARM lasts zero cycles: reset and load go directly to RUN.
- RUN:
  - valid_o=1.
  - Advance only on a handshake: en_i & valid_o & ready_i.
  - With ready_i=0 or en_i=0, data_o holds.
- data_o is the registered state. The word following a handshake appears the next cycle.
- load_i=1, regardless of en_i:
  - State loads seed_i, or SEED if seed_i==0.
  - wcnt clears.
  - FSM enters WARM, or RUN if WARMUP=0.
  - Any handshake in the same cycle is discarded; the word is not advanced.
- Priority: reset_i > load_i > lockup recovery > advance.
- Lockup: if an advance result equals zero, see Configuration.

## Timing
- Reset values: state=SEED, data_o=SEED, wcnt=0, lockup_o=0, valid_o=(WARMUP==0).
- FSM after reset: WARM if WARMUP>0, else RUN.
- First valid after reset: the cycle after WARMUP cycles with en_i=1. If WARMUP=0, valid from the first post-reset cycle.
- Throughput: one word per cycle with en_i=ready_i=1.
- Latency: handshake in cycle n puts the next word on data_o in cycle n+1.
- lockup_o is registered and high for exactly the cycle in which data_o shows the recovered SEED.
- Reset asserted mid-warm-up or mid-stream: the next cycle equals the reset values. No partial handshake is retained.
- load_i held for several cycles: reloads each cycle, so valid_o stays 0 throughout when WARMUP>0.

## Configuration
- LFSR_LOCKUP_RECOVER_EN defined:
  - An all-zero advance result is replaced by SEED.
  - lockup_o pulses for one cycle.
  - wcnt and the FSM are unaffected; the replaced advance still counts.
- Not defined:
  - An all-zero state persists; the LFSR yields zeros until load or reset.
  - lockup_o is tied 0.

## Test plan
- Defaults, WARMUP=0, en_i=ready_i=1:
  - After reset: data_o=0x00BD6D01, valid_o=1.
  - Next cycle: data_o=0x017ADA02.
- Stall: ready_i=0 for 5 cycles after reset -> data_o holds 0x00BD6D01 and valid_o stays 1. Release -> 0x017ADA02 the next cycle.
- WARMUP=3, en_i toggled 1,0,1,1 after reset -> valid_o rises only after the 3rd enabled cycle. data_o equals SEED advanced 3 times.
- load_i with seed_i=0x12345678 in the same cycle as a handshake -> next data_o=0x12345678, with no advance applied. load_i with seed_i=0 -> data_o=SEED.
- Lockup, macro on, WIDTH=4, TAPS=4'b0010, SEED=4'h1: load 4'b1000, handshake -> data_o=4'h1 and lockup_o=1 for one cycle. With macro off -> data_o=4'h0 and stays 0.
- STEPS=8, defaults -> one handshake yields a word equal to eight single-step advances of 0x00BD6D01, checked against a reference model.
